// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard inputs, stage hold/flush controls,
// the data-memory handshake and status outputs.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs1_i;
    logic [4:0]       ID_rs2_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_rd_i;
    logic             branch_taken_i;
    logic             MEM_MemRead_i;
    logic             MEM_MemWrite_i;
    logic             dmem_ack_i;
    logic             PC_write_o;
    logic             IFID_write_o;
    logic             IFID_flush_o;
    logic             IDEX_hold_o;
    logic             IDEX_flush_o;
    logic             EXMEM_hold_o;
    logic             MEMWB_bubble_o;
    logic             dmem_req_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Pipeline side: supplies hazard/memory status, consumes stage controls.
    modport master (
        output ID_rs1_i, ID_rs2_i, EX_MemRead_i, EX_rd_i, branch_taken_i,
               MEM_MemRead_i, MEM_MemWrite_i, dmem_ack_i,
        input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_hold_o, IDEX_flush_o,
               EXMEM_hold_o, MEMWB_bubble_o, dmem_req_o, timeout_o, stall_cnt_o
    );

    // Controller side.
    modport slave (
        input  ID_rs1_i, ID_rs2_i, EX_MemRead_i, EX_rd_i, branch_taken_i,
               MEM_MemRead_i, MEM_MemWrite_i, dmem_ack_i,
        output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_hold_o, IDEX_flush_o,
               EXMEM_hold_o, MEMWB_bubble_o, dmem_req_o, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch hazards,
// data-memory req/ack wait with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dmem_req_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_cnt;

    logic mem_op;
    logic lu;
    logic freeze;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        mem_op = bus.MEM_MemRead_i | bus.MEM_MemWrite_i;
        lu     = bus.EX_MemRead_i && (bus.EX_rd_i != 5'd0) &&
                 ((bus.EX_rd_i == bus.ID_rs1_i) || (bus.EX_rd_i == bus.ID_rs2_i));
    end

    // Next state and freeze decision; an ack on the final wait cycle beats the timeout.
    always_comb begin
        state_nxt = state;
        freeze    = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (mem_op) begin
                    freeze    = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ack_i) begin
                    state_nxt = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                freeze    = 1'b1;
                state_nxt = ST_ERR;
            end
        endcase
    end

    // Hazard handling applies only when the pipeline is not frozen for memory.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else begin
            ifid_flush = bus.branch_taken_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            dmem_req_q <= 1'b0;
            timeout_q  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= (state == ST_MEM_WAIT && !bus.dmem_ack_i) ? wait_cnt + WAIT_W'(1) : '0;
            dmem_req_q <= (state_nxt == ST_MEM_WAIT);
            timeout_q  <= (state_nxt == ST_ERR);
            if (!pc_write) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    always_comb begin
        bus.PC_write_o     = pc_write;
        bus.IFID_write_o   = ifid_write;
        bus.IFID_flush_o   = ifid_flush;
        bus.IDEX_hold_o    = freeze;
        bus.IDEX_flush_o   = idex_flush;
        bus.EXMEM_hold_o   = freeze;
        bus.MEMWB_bubble_o = freeze;
        bus.dmem_req_o     = dmem_req_q;
        bus.timeout_o      = timeout_q;
        bus.stall_cnt_o    = stall_cnt;
    end

endmodule
